rx_frame_checker: RTL

//  Downstream of the RX FIFO, in the i_clk_tx domain. Consumes the byte stream the FIFO drains:
//  i_en, i_error and i_data per byte, with i_en held high for the whole frame.

---
 rtl/rx_frame_checker_if.sv | 11 +
 rtl/rx_frame_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_checker_if.sv
// Byte stream drained from the RX FIFO: one byte per cycle while i_en is high.
interface rx_frame_checker_if #(
  parameter int unsigned pDATA = 8
);
  logic             i_en;
  logic             i_error;
  logic [pDATA-1:0] i_data;

  modport master (output i_en, output i_error, output i_data);
  modport slave  (input  i_en, input  i_error, input  i_data);
endinterface

// File: rtl/rx_frame_checker.sv
// Per-frame checker behind the RX FIFO: extracts DA/SA, checks the CRC-32 FCS,
// counts bytes and reports a one-cycle end-of-frame status.
module rx_frame_checker #(
  parameter int unsigned pDATA    = 8,
  parameter int unsigned pMIN_LEN = 64,
  parameter int unsigned pMAX_LEN = 1518,
  parameter int unsigned pLEN_W   = 11
) (
  input  logic                 i_clk_tx,
  input  logic                 ireset_n,
  rx_frame_checker_if.slave    rx_i,
  output logic                 o_hdr_valid,
  output logic [47:0]          o_dst_mac,
  output logic [47:0]          o_src_mac,
  output logic                 o_done,
  output logic [pLEN_W-1:0]    o_len,
  output logic                 o_crc_ok,
  output logic [3:0]           o_status
);

  localparam int unsigned MAC_W   = 48;
  localparam int unsigned SA_SH_W = MAC_W - pDATA;
  localparam logic [31:0] POLY    = 32'hEDB8_8320;
  localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

  localparam logic [pLEN_W-1:0] MIN_LEN  = pLEN_W'(pMIN_LEN);
  localparam logic [pLEN_W-1:0] MAX_LEN  = pLEN_W'(pMAX_LEN);
  localparam logic [pLEN_W-1:0] LEN_SAT  = '1;
  localparam logic [pLEN_W-1:0] LEN_ONE  = pLEN_W'(1);
  localparam logic [pLEN_W-1:0] DA_LAST  = pLEN_W'(5);
  localparam logic [pLEN_W-1:0] HDR_LAST = pLEN_W'(11);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [pLEN_W-1:0]   cnt_q, cnt_d;
  logic [31:0]         crc_q, crc_d;
  logic                err_q, err_d;
  logic [MAC_W-1:0]    da_q, da_d;
  logic [SA_SH_W-1:0]  sa_q, sa_d;
  logic [MAC_W-1:0]    dst_q, dst_d;
  logic [MAC_W-1:0]    src_q, src_d;
  logic                hdr_valid_q, hdr_valid_d;
  logic                done_q, done_d;
  logic [pLEN_W-1:0]   len_q, len_d;
  logic                crc_ok_q, crc_ok_d;
  logic [3:0]          status_q, status_d;

  logic [31:0]         crc_first_c;
  logic [31:0]         crc_next_c;
  logic [pLEN_W-1:0]   cnt_inc_c;
  logic                final_ok_c;

  // Reflected CRC-32 over one input word, LSB first.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [pDATA-1:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < int'(pDATA); i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_first_c = crc_upd(32'hFFFF_FFFF, rx_i.i_data);
  assign crc_next_c  = crc_upd(crc_q, rx_i.i_data);
  assign cnt_inc_c   = (cnt_q == LEN_SAT) ? cnt_q : cnt_q + LEN_ONE;
  assign final_ok_c  = (crc_q == RESIDUE);

  always_ff @(posedge i_clk_tx) begin
    if (!ireset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      crc_q       <= '0;
      err_q       <= 1'b0;
      da_q        <= '0;
      sa_q        <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      hdr_valid_q <= 1'b0;
      done_q      <= 1'b0;
      len_q       <= '0;
      crc_ok_q    <= 1'b0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      err_q       <= err_d;
      da_q        <= da_d;
      sa_q        <= sa_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      hdr_valid_q <= hdr_valid_d;
      done_q      <= done_d;
      len_q       <= len_d;
      crc_ok_q    <= crc_ok_d;
      status_q    <= status_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    err_d       = err_q;
    da_d        = da_q;
    sa_d        = sa_q;
    dst_d       = dst_q;
    src_d       = src_q;
    hdr_valid_d = 1'b0;
    done_d      = 1'b0;
    len_d       = len_q;
    crc_ok_d    = crc_ok_q;
    status_d    = status_q;

    case (state_q)
      S_IDLE: begin
        if (rx_i.i_en) begin
          state_d = S_HDR;
          cnt_d   = LEN_ONE;
          crc_d   = crc_first_c;
          err_d   = rx_i.i_error;
          da_d    = {da_q[MAC_W-pDATA-1:0], rx_i.i_data};
        end
      end
      S_HDR: begin
        if (rx_i.i_en) begin
          cnt_d = cnt_inc_c;
          crc_d = crc_next_c;
          err_d = err_q | rx_i.i_error;
          if (cnt_q <= DA_LAST) begin
            da_d = {da_q[MAC_W-pDATA-1:0], rx_i.i_data};
          end else begin
            sa_d = {sa_q[SA_SH_W-pDATA-1:0], rx_i.i_data};
          end
          // Last SA byte goes straight to the output so both MACs update together.
          if (cnt_q == HDR_LAST) begin
            state_d     = S_BODY;
            hdr_valid_d = 1'b1;
            dst_d       = da_q;
            src_d       = {sa_q, rx_i.i_data};
          end
        end
      end
      S_BODY: begin
        if (rx_i.i_en) begin
          cnt_d = cnt_inc_c;
          crc_d = crc_next_c;
          err_d = err_q | rx_i.i_error;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // End of frame: latch the result, reported on the following cycle.
    if ((state_q != S_IDLE) && !rx_i.i_en) begin
      state_d  = S_IDLE;
      done_d   = 1'b1;
      len_d    = cnt_q;
      crc_ok_d = final_ok_c;
      status_d = {(cnt_q > MAX_LEN) || (cnt_q == LEN_SAT),
                  (cnt_q < MIN_LEN),
                  err_q,
                  ~final_ok_c};
    end
  end

  assign o_hdr_valid = hdr_valid_q;
  assign o_dst_mac   = dst_q;
  assign o_src_mac   = src_q;
  assign o_done      = done_q;
  assign o_len       = len_q;
  assign o_crc_ok    = crc_ok_q;
  assign o_status    = status_q;

endmodule
